// File: rtl/dcache_wq_pkg.sv
// Shared types and constants for the dcache writeback queue.
// Line geometry is fixed here so the top, the match unit and the bench all agree on entry layout.
package dcache_wq_pkg;

    localparam int TAG_W   = 28;
    localparam int INDEX_W = 1;
    localparam int WORDS   = 2;
    localparam int WORD_W  = 32;

    // data[0] occupies the low 32 bits, matching the flat enqueue bus.
    typedef struct packed {
        logic [TAG_W-1:0]             tag;
        logic [INDEX_W-1:0]           index;
        logic [WORDS-1:0][WORD_W-1:0] data;
    } wq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wq_state_e;

endpackage

// File: rtl/dcache_write_queue_match.sv
// Combinational lookup over queued lines; returns hit and the youngest matching line's data.
// Zero latency, no backpressure; data is forced to 0 on a miss.
module dcache_write_queue_match
    import dcache_wq_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wq_entry_t                entries [DEPTH],
    input  logic [DEPTH-1:0]         occ,
    input  logic [PTR_W-1:0]         tail,
    input  logic [TAG_W-1:0]         q_tag,
    input  logic [INDEX_W-1:0]       q_index,
    output logic                     hit,
    output logic [WORDS*WORD_W-1:0]  data
);

    logic [PTR_W-1:0] idx;

    // Walk backwards from the newest slot so the first match found is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail - PTR_W'(k);
            if (!hit && occ[idx] &&
                entries[idx].tag == q_tag && entries[idx].index == q_index) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dcache_write_queue.sv
// Writeback FIFO of evicted lines; drains each as one address beat then WORDS data beats.
// Address valid two edges after enqueue into an idle empty queue; outputs held under backpressure.
module dcache_write_queue
    import dcache_wq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_enq_valid,
    output logic                     io_enq_ready,
    input  logic [TAG_W-1:0]         io_enq_bits_tag,
    input  logic [INDEX_W-1:0]       io_enq_bits_index,
    input  logic [WORDS*WORD_W-1:0]  io_enq_bits_data,
    input  logic [TAG_W-1:0]         io_query_tag,
    input  logic [INDEX_W-1:0]       io_query_index,
    output logic                     io_query_hit,
    output logic [WORDS*WORD_W-1:0]  io_query_data,
    output logic                     io_addrRequest_valid,
    input  logic                     io_addrRequest_ready,
    output logic [TAG_W-1:0]         io_addrRequest_bits_tag,
    output logic [INDEX_W-1:0]       io_addrRequest_bits_index,
    output logic                     io_data_valid,
    input  logic                     io_data_ready,
    output logic [WORD_W-1:0]        io_data_bits,
    output logic                     io_dataLast,
    output logic                     io_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(WORDS);

    wq_state_e          state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WCNT_W-1:0]  word_q, word_d;
    wq_entry_t          entries_q [DEPTH];
    wq_entry_t          entries_d [DEPTH];
    logic [DEPTH-1:0]   occ;

    logic enq_fire;
    logic data_fire;
    logic last_word;
    logic pop;

    assign io_enq_ready = (count_q != CNT_W'(DEPTH));
    assign io_empty     = (count_q == '0);
    assign enq_fire     = io_enq_valid && io_enq_ready;
    assign last_word    = (word_q == WCNT_W'(WORDS - 1));
    assign data_fire    = (state_q == DATA) && io_data_ready;
    assign pop          = data_fire && last_word;

    assign io_addrRequest_valid      = (state_q == ADDR);
    assign io_addrRequest_bits_tag   = entries_q[head_q].tag;
    assign io_addrRequest_bits_index = entries_q[head_q].index;
    assign io_data_valid             = (state_q == DATA);
    assign io_data_bits              = entries_q[head_q].data[word_q];
    assign io_dataLast               = last_word;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        word_d    = word_q;
        entries_d = entries_q;

        case (state_q)
            IDLE: if (count_q != '0) state_d = ADDR;
            ADDR: begin
                if (io_addrRequest_ready) begin
                    state_d = DATA;
                    word_d  = '0;
                end
            end
            DATA: begin
                if (data_fire) begin
                    if (last_word) begin
                        state_d = IDLE;
                        head_d  = head_q + 1'b1;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enq_fire) begin
            entries_d[tail_q].tag   = io_enq_bits_tag;
            entries_d[tail_q].index = io_enq_bits_index;
            entries_d[tail_q].data  = io_enq_bits_data;
            tail_d                  = tail_q + 1'b1;
        end

        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(pop);
    end

    // Slot i is live when its distance from head is below the occupancy count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    // Line storage is gated by occupancy, so it needs no reset.
    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

    dcache_write_queue_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries_q),
        .occ     (occ),
        .tail    (tail_q),
        .q_tag   (io_query_tag),
        .q_index (io_query_index),
        .hit     (io_query_hit),
        .data    (io_query_data)
    );

endmodule
